// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory port bundle: request/grant issue channel plus in-order response channel.
// Latency: none; wires only. Responses return at least one cycle after the granting cycle.
// Backpressure: gnt low holds a request in place; the fetch stage bounds its own in-flight count.
interface if_prefetch_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    // Fetch stage side: issues requests, consumes grants and responses.
    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    // Memory side: accepts requests, returns grants and responses.
    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage: prefetches sequential instructions into a DEPTH-entry queue ahead of IF/ID.
// Latency: rvalid to valid 1 cycle; grant to earliest valid 2 cycles; taken branch to first valid 3 cycles.
// Backpressure: freeze holds the head; imem_req drops once queued plus in-flight entries reach DEPTH.
module if_prefetch_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         branch_taken,
    input  logic [ADDR_W-1:0]            branch_address,
    input  logic                         freeze,
    if_prefetch_stage_if.master          imem,
    output logic [ADDR_W-1:0]            pc,
    output logic [DATA_W-1:0]            instruction,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    // Stale responses accumulate across back-to-back branches, so this counter is
    // wider than the in-flight limit of a single fetch stream.
    localparam int unsigned STALE_W = CNT_W + 4;

    localparam logic [PTR_W:0]      PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [ADDR_W-1:0]   STEP     = ADDR_W'(PC_STEP);
    localparam logic [CNT_W:0]      CREDITS  = (CNT_W+1)'(DEPTH);

    // Architectural fetch state.
    logic [ADDR_W-1:0]  fetch_pc_q,    fetch_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [STALE_W-1:0] stale_q,       stale_d;

    // Instruction queue pointers (one extra wrap bit) and storage.
    logic [PTR_W:0]     q_wptr_q, q_wptr_d;
    logic [PTR_W:0]     q_rptr_q, q_rptr_d;
    logic [ADDR_W-1:0]  q_addr_q [DEPTH];
    logic [DATA_W-1:0]  q_data_q [DEPTH];

    // Address FIFO of issued, still-live requests; responses pair with its head in order.
    logic [PTR_W:0]     a_wptr_q, a_wptr_d;
    logic [PTR_W:0]     a_rptr_q, a_rptr_d;
    logic [ADDR_W-1:0]  a_addr_q [DEPTH];

    logic [CNT_W:0]     credit_used;
    logic               issue;
    logic               rv_stale;
    logic               rv_ok;
    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   head_idx;

    assign occupancy   = CNT_W'(q_wptr_q - q_rptr_q);
    assign valid       = (occupancy != '0);
    assign head_idx    = q_rptr_q[PTR_W-1:0];

    // Credits cover both queued entries and responses still in flight, so a push never
    // finds the queue full.
    assign credit_used = {1'b0, occupancy} + {1'b0, outstanding_q};
    assign imem.req    = !rst && !branch_taken && (credit_used < CREDITS);
    assign imem.addr   = fetch_pc_q;
    assign issue       = imem.req && imem.gnt;

    // A response is either owed to a flushed stream (dropped) or to a live request.
    // A response with nothing outstanding at all is a protocol error and is ignored.
    assign rv_stale    = imem.rvalid && (stale_q != '0);
    assign rv_ok       = imem.rvalid && (stale_q == '0) && (outstanding_q != '0);
    assign push        = rv_ok && !branch_taken;
    assign pop         = valid && !freeze && !branch_taken;

    // ARM convention: the visible PC is one step beyond the head instruction's address.
    assign pc          = valid ? (q_addr_q[head_idx] + STEP) : '0;
    assign instruction = valid ? q_data_q[head_idx] : '0;

    // Next-state: a taken branch flushes everything and turns in-flight requests stale.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        stale_d       = stale_q;
        q_wptr_d      = q_wptr_q;
        q_rptr_d      = q_rptr_q;
        a_wptr_d      = a_wptr_q;
        a_rptr_d      = a_rptr_q;
        if (branch_taken) begin
            fetch_pc_d    = branch_address;
            q_rptr_d      = q_wptr_q;
            a_rptr_d      = a_wptr_q;
            outstanding_d = '0;
            // Any response landing this cycle retires one request from whichever
            // pool it belonged to; everything else still in flight becomes stale.
            stale_d       = stale_q + STALE_W'(outstanding_q)
                          - STALE_W'(rv_stale) - STALE_W'(rv_ok);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + STEP;
                a_wptr_d   = a_wptr_q + PTR_ONE;
            end
            if (rv_ok) begin
                a_rptr_d = a_rptr_q + PTR_ONE;
            end
            if (push) begin
                q_wptr_d = q_wptr_q + PTR_ONE;
            end
            if (pop) begin
                q_rptr_d = q_rptr_q + PTR_ONE;
            end
            outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rv_ok);
            stale_d       = stale_q - STALE_W'(rv_stale);
        end
    end

    // State register: reset restarts fetch at RESET_PC and forgets every in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
            q_wptr_q      <= '0;
            q_rptr_q      <= '0;
            a_wptr_q      <= '0;
            a_rptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
            q_wptr_q      <= q_wptr_d;
            q_rptr_q      <= q_rptr_d;
            a_wptr_q      <= a_wptr_d;
            a_rptr_q      <= a_rptr_d;
        end
    end

    // Storage: record issued addresses, and capture {address, instruction} on accepted responses.
    always_ff @(posedge clk) begin
        if (issue) begin
            a_addr_q[a_wptr_q[PTR_W-1:0]] <= fetch_pc_q;
        end
        if (push) begin
            q_addr_q[q_wptr_q[PTR_W-1:0]] <= a_addr_q[a_rptr_q[PTR_W-1:0]];
            q_data_q[q_wptr_q[PTR_W-1:0]] <= imem.rdata;
        end
    end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for the fetch stage: a small memory responder with programmable grant and latency.
// Inputs are driven right after the falling edge; registered outputs are read there, imem_req/addr 4ns later.
// Responder drives gnt/rvalid 1ns after the falling edge and records grants 3ns after it.
module tb_if_prefetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        freeze;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;
    logic [2:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    // Responder controls.
    bit gnt_en    = 1'b0;
    bit hold_resp = 1'b0;
    int lat       = 1;
    int cyc       = 0;
    typedef struct { logic [31:0] a; int due; } pend_t;
    pend_t pend[$];

    if_prefetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem ();

    if_prefetch_stage #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_address(branch_address),
        .freeze(freeze), .imem(imem), .pc(pc), .instruction(instruction),
        .valid(valid), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hE59F_0000;
    endfunction

    // Memory responder: in-order responses `lat` cycles after the granting cycle.
    initial begin
        pend_t p;
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            imem.gnt = gnt_en;
            if (!hold_resp && pend.size() > 0 && pend[0].due <= cyc) begin
                imem.rvalid = 1'b1;
                imem.rdata  = memf(pend[0].a);
                void'(pend.pop_front());
            end else begin
                imem.rvalid = 1'b0;
                imem.rdata  = '0;
            end
            #2;
            if (imem.req && imem.gnt) begin
                p.a   = imem.addr;
                p.due = cyc + lat;
                pend.push_back(p);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Leaves the bench at the falling edge of the first cycle with rst low.
    task automatic do_reset();
        rst = 1'b1; branch_taken = 1'b0; branch_address = '0; freeze = 1'b0;
        gnt_en = 1'b0; hold_resp = 1'b0; lat = 1;
        pend.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; branch_taken = 1'b0; branch_address = '0; freeze = 1'b0;
        gnt_en = 1'b1; hold_resp = 1'b0; lat = 1;
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", pc); end
        checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h want=0", instruction); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
        checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", imem.req); end
        tick();
        tick();
        #4;
        checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL reset_req_held got=%b want=0", imem.req); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid_held got=%b want=0", valid); end
    endtask

    task automatic test_sequential();
        do_reset();
        gnt_en = 1'b1;
        #4;
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin failures++;
            $display("FAIL seq_first_req got req=%b addr=%h want req=1 addr=0", imem.req, imem.addr); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                checks++; if (valid !== 1'b0) begin failures++; $display("FAIL seq_early_valid got=%b want=0", valid); end
            end else begin
                checks++; if (valid !== 1'b1) begin failures++; $display("FAIL seq_valid k=%0d got=%b want=1", k, valid); end
                checks++; if (pc !== 32'(4 * (k - 1))) begin failures++;
                    $display("FAIL seq_pc k=%0d got=%h want=%h", k, pc, 32'(4 * (k - 1))); end
                checks++; if (instruction !== memf(32'(4 * (k - 2)))) begin failures++;
                    $display("FAIL seq_instr k=%0d got=%h want=%h", k, instruction, memf(32'(4 * (k - 2)))); end
                checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL seq_occ k=%0d got=%0d want=1", k, occupancy); end
            end
            #4;
            checks++; if (imem.req !== 1'b1 || imem.addr !== 32'(4 * k)) begin failures++;
                $display("FAIL seq_addr k=%0d got req=%b addr=%h want req=1 addr=%h", k, imem.req, imem.addr, 32'(4 * k)); end
        end
    endtask

    task automatic test_freeze();
        int n = 0;
        do_reset();
        freeze = 1'b1;
        gnt_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 6) begin
                checks++; if (valid !== 1'b1 || pc !== 32'h4) begin failures++;
                    $display("FAIL frz_head_mid got valid=%b pc=%h want valid=1 pc=4", valid, pc); end
            end
            #4;
            if (imem.req && imem.gnt) n++;
            tick();
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL frz_issued got=%0d want=4", n); end
        checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL frz_occ got=%0d want=4", occupancy); end
        checks++; if (pc !== 32'h4 || instruction !== memf(32'h0)) begin failures++;
            $display("FAIL frz_head got pc=%h instr=%h want pc=4 instr=%h", pc, instruction, memf(32'h0)); end
        #4;
        checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL frz_req got=%b want=0", imem.req); end
        freeze = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            checks++; if (valid !== 1'b1 || pc !== 32'(4 * j + 4) || instruction !== memf(32'(4 * j))) begin failures++;
                $display("FAIL frz_drain j=%0d got valid=%b pc=%h instr=%h want pc=%h instr=%h",
                         j, valid, pc, instruction, 32'(4 * j + 4), memf(32'(4 * j))); end
        end
    endtask

    task automatic test_branch_outstanding();
        do_reset();
        lat = 3;
        gnt_en = 1'b1;
        tick();
        tick();
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL br_pre_occ got=%0d want=0", occupancy); end
        branch_taken = 1'b1;
        branch_address = 32'h100;
        #4;
        checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL br_req_low got=%b want=0", imem.req); end
        tick();
        branch_taken = 1'b0;
        #4;
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin failures++;
            $display("FAIL br_target got req=%b addr=%h want req=1 addr=100", imem.req, imem.addr); end
        for (int k = 4; k <= 6; k++) begin
            tick();
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL br_stale_drop k=%0d got valid=%b want=0", k, valid); end
        end
        tick();
        checks++; if (valid !== 1'b1 || pc !== 32'h104 || instruction !== memf(32'h100)) begin failures++;
            $display("FAIL br_first got valid=%b pc=%h instr=%h want pc=104 instr=%h", valid, pc, instruction, memf(32'h100)); end
    endtask

    task automatic test_branch_rvalid_freeze();
        do_reset();
        freeze = 1'b1;
        gnt_en = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL brf_pre_occ got=%0d want=3", occupancy); end
        branch_taken = 1'b1;
        branch_address = 32'h200;
        #4;
        checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL brf_req_low got=%b want=0", imem.req); end
        tick();
        branch_taken = 1'b0;
        checks++; if (occupancy !== 3'd0 || valid !== 1'b0) begin failures++;
            $display("FAIL brf_flush got occ=%0d valid=%b want occ=0 valid=0", occupancy, valid); end
        #4;
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h200) begin failures++;
            $display("FAIL brf_target got req=%b addr=%h want req=1 addr=200", imem.req, imem.addr); end
        tick();
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL brf_dropped got occ=%0d want=0", occupancy); end
        tick();
        checks++; if (occupancy !== 3'd1 || pc !== 32'h204 || instruction !== memf(32'h200)) begin failures++;
            $display("FAIL brf_first got occ=%0d pc=%h instr=%h want occ=1 pc=204 instr=%h", occupancy, pc, instruction, memf(32'h200)); end
    endtask

    task automatic test_gnt_stall_wrap();
        do_reset();
        gnt_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #4;
            checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin failures++;
                $display("FAIL gnt_hold k=%0d got req=%b addr=%h want req=1 addr=0", k, imem.req, imem.addr); end
            tick();
        end
        gnt_en = 1'b1;
        tick();
        branch_taken = 1'b1;
        branch_address = 32'hFFFF_FFFC;
        #4;
        checks++; if (imem.addr !== 32'h4) begin failures++; $display("FAIL gnt_advance got=%h want=4", imem.addr); end
        tick();
        branch_taken = 1'b0;
        #4;
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'hFFFF_FFFC) begin failures++;
            $display("FAIL wrap_target got req=%b addr=%h want req=1 addr=fffffffc", imem.req, imem.addr); end
        tick();
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL wrap_drop got occ=%0d want=0", occupancy); end
        #4;
        checks++; if (imem.addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h want=0", imem.addr); end
        tick();
        checks++; if (valid !== 1'b1 || pc !== 32'h0 || instruction !== memf(32'hFFFF_FFFC)) begin failures++;
            $display("FAIL wrap_head got valid=%b pc=%h instr=%h want pc=0 instr=%h", valid, pc, instruction, memf(32'hFFFF_FFFC)); end
    endtask

    task automatic test_reset_outstanding();
        do_reset();
        freeze = 1'b1;
        gnt_en = 1'b1;
        tick();
        lat = 3;
        tick();
        tick();
        gnt_en = 1'b0;
        checks++; if (valid !== 1'b1 || pc !== 32'h4 || occupancy !== 3'd1) begin failures++;
            $display("FAIL rst_pre got valid=%b pc=%h occ=%0d want valid=1 pc=4 occ=1", valid, pc, occupancy); end
        rst = 1'b1;
        hold_resp = 1'b1;
        #2;
        checks++; if (valid !== 1'b0 || pc !== 32'h0 || instruction !== 32'h0 || occupancy !== 3'd0 || imem.req !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got valid=%b pc=%h instr=%h occ=%0d req=%b want all 0",
                     valid, pc, instruction, occupancy, imem.req); end
        tick();
        tick();
        rst = 1'b0;
        hold_resp = 1'b0;
        #4;
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin failures++;
            $display("FAIL rst_restart got req=%b addr=%h want req=1 addr=0", imem.req, imem.addr); end
        tick();
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL rst_late1 got occ=%0d want=0", occupancy); end
        tick();
        checks++; if (occupancy !== 3'd0 || valid !== 1'b0) begin failures++;
            $display("FAIL rst_late2 got occ=%0d valid=%b want occ=0 valid=0", occupancy, valid); end
        gnt_en = 1'b1;
        lat = 1;
        tick();
        tick();
        checks++; if (occupancy !== 3'd1 || pc !== 32'h4 || instruction !== memf(32'h0)) begin failures++;
            $display("FAIL rst_first got occ=%0d pc=%h instr=%h want occ=1 pc=4 instr=%h", occupancy, pc, instruction, memf(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_freeze();
        test_branch_outstanding();
        test_branch_rvalid_freeze();
        test_gnt_stall_wrap();
        test_reset_outstanding();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
